// File: rtl/bldc_adc_sched.sv
// bldc_adc_sched: arbitrates the shared ADC command/response port.
// A PWM trigger runs a sampling sequence (masked currents ch0-2, then masked
// voltages ch3-5); software single-shot conversions fill the idle gaps.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   en_i, trig_i               scheduler enable, PWM sample trigger
//   cur_mask_i, volt_mask_i    per-channel enables, latched at trigger
//   sw_req_i/sw_ch_i           software request (level) and channel
//   sw_ack_o/sw_done_o/sw_data_o  software accept pulse, result pulse, data
//   cmd_vld_o/cmd_ch_o/cmd_ready_i  ADC command handshake
//   rsp_vld_i/rsp_ch_i/rsp_data_i   ADC in-order responses
//   res_vld_o/res_ch_o/res_data_o   sequence result stream
//   seq_busy_o, seq_done_o     sequence status
//   trig_miss_o, tmo_err_o     sticky errors, cleared by clr_err_i
module bldc_adc_sched #(
  parameter int MAX_OUT = 4,
  parameter int TMO_W   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        trig_i,
  input  logic [2:0]  cur_mask_i,
  input  logic [2:0]  volt_mask_i,
  input  logic        sw_req_i,
  input  logic [4:0]  sw_ch_i,
  output logic        sw_ack_o,
  output logic        sw_done_o,
  output logic [11:0] sw_data_o,
  output logic        cmd_vld_o,
  output logic [4:0]  cmd_ch_o,
  input  logic        cmd_ready_i,
  input  logic        rsp_vld_i,
  input  logic [4:0]  rsp_ch_i,
  input  logic [11:0] rsp_data_i,
  output logic        res_vld_o,
  output logic [4:0]  res_ch_o,
  output logic [11:0] res_data_o,
  output logic        seq_busy_o,
  output logic        seq_done_o,
  output logic        trig_miss_o,
  output logic        tmo_err_o,
  input  logic        clr_err_i
);
  localparam int CW = $clog2(MAX_OUT + 1);
  // Counter value one short of all-ones: the increment that would reach
  // all-ones is the timeout event.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_CUR, S_VOLT, S_DRAIN, S_SW, S_SWW} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_out_cnt, w_cnt_nxt;
  logic [5:0]       r_pend, w_pend_nxt;   // channels of this sequence not yet transferred
  logic [TMO_W-1:0] r_tmo;
  logic             w_xfer, w_rsp, w_tmo_inc, w_tmo_fire;
  logic             w_cmd_vld_nxt;
  logic [4:0]       w_cmd_ch_nxt;

  assign w_xfer     = cmd_vld_o & cmd_ready_i;
  assign w_rsp      = rsp_vld_i & (r_out_cnt != '0);  // stray responses are ignored
  assign w_tmo_inc  = (r_state == S_DRAIN || r_state == S_SWW) && (r_out_cnt != '0) && !rsp_vld_i;
  assign w_tmo_fire = w_tmo_inc && (r_tmo == TMO_LAST);

  always_comb begin
    w_cnt_nxt = r_out_cnt;
    if (w_tmo_fire)            w_cnt_nxt = '0;
    else if (w_xfer && !w_rsp) w_cnt_nxt = r_out_cnt + 1'b1;
    else if (!w_xfer && w_rsp) w_cnt_nxt = r_out_cnt - 1'b1;
  end

  always_comb begin
    w_pend_nxt = r_pend;
    if (r_state == S_IDLE && trig_i && en_i) w_pend_nxt = {volt_mask_i, cur_mask_i};
    if ((r_state == S_CUR || r_state == S_VOLT) && w_xfer)
      for (int i = 0; i < 6; i++)
        if (cmd_ch_o == 5'(i)) w_pend_nxt[i] = 1'b0;
    if ((r_state == S_CUR || r_state == S_VOLT) && !en_i) w_pend_nxt = '0;
  end

  // State register (plus the counters that move with it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_out_cnt <= '0;
      r_pend    <= '0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_out_cnt <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_tmo     <= (w_tmo_inc && w_state_nxt == r_state) ? r_tmo + 1'b1 : '0;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (trig_i && en_i)                            w_state_nxt = S_CUR;
               else if (sw_req_i && en_i && r_out_cnt == '0)  w_state_nxt = S_SW;
      S_CUR:   if (!en_i)                                     w_state_nxt = S_DRAIN;
               else if (w_pend_nxt[2:0] == '0)                w_state_nxt = S_VOLT;
      S_VOLT:  if (!en_i || w_pend_nxt[5:3] == '0)            w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_tmo_fire || r_out_cnt == '0)             w_state_nxt = S_IDLE;
      S_SW:    if (w_xfer)                                    w_state_nxt = S_SWW;
               else if (!en_i)                                w_state_nxt = S_IDLE;
      S_SWW:   if (w_tmo_fire || w_rsp)                       w_state_nxt = S_IDLE;
      default:                                                w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next command is the lowest pending channel of the phase the
  // FSM enters, so a stalled command keeps its channel and the phases run
  // back to back. The outstanding limit is judged on next-cycle occupancy.
  always_comb begin
    w_cmd_vld_nxt = 1'b0;
    w_cmd_ch_nxt  = cmd_ch_o;
    if (w_state_nxt == S_CUR || w_state_nxt == S_VOLT) begin
      for (int i = 5; i >= 0; i--)
        if (w_pend_nxt[i] && ((w_state_nxt == S_CUR) == (i < 3))) begin
          w_cmd_vld_nxt = (w_cnt_nxt < CW'(MAX_OUT));
          w_cmd_ch_nxt  = 5'(i);
        end
    end else if (w_state_nxt == S_SW) begin
      w_cmd_vld_nxt = 1'b1;
      if (r_state != S_SW) w_cmd_ch_nxt = sw_ch_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_vld_o   <= 1'b0;
      cmd_ch_o    <= '0;
      sw_ack_o    <= 1'b0;
      sw_done_o   <= 1'b0;
      sw_data_o   <= '0;
      res_vld_o   <= 1'b0;
      res_ch_o    <= '0;
      res_data_o  <= '0;
      seq_busy_o  <= 1'b0;
      seq_done_o  <= 1'b0;
      trig_miss_o <= 1'b0;
      tmo_err_o   <= 1'b0;
    end else begin
      cmd_vld_o  <= w_cmd_vld_nxt;
      cmd_ch_o   <= w_cmd_ch_nxt;
      sw_ack_o   <= (r_state == S_SW) && w_xfer;
      sw_done_o  <= (r_state == S_SWW) && w_rsp;
      if ((r_state == S_SWW) && w_rsp) sw_data_o <= rsp_data_i;
      res_vld_o  <= w_rsp && seq_busy_o;
      if (w_rsp && seq_busy_o) begin
        res_ch_o   <= rsp_ch_i;
        res_data_o <= rsp_data_i;
      end
      seq_busy_o <= (w_state_nxt == S_CUR) || (w_state_nxt == S_VOLT) || (w_state_nxt == S_DRAIN);
      // Pulses in the single DRAIN cycle that sees no outstanding commands
      seq_done_o <= (w_state_nxt == S_DRAIN) && (w_cnt_nxt == '0);
      if (trig_i && r_state != S_IDLE) trig_miss_o <= 1'b1;
      else if (clr_err_i)              trig_miss_o <= 1'b0;
      if (w_tmo_fire)                  tmo_err_o   <= 1'b1;
      else if (clr_err_i)              tmo_err_o   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bldc_adc_sched.sv
// Scoreboard bench for bldc_adc_sched: stimulus pushes expected commands and
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_bldc_adc_sched;
  localparam int MAXO = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en_i = 0, trig_i = 0, sw_req_i = 0, cmd_ready_i = 0, clr_err_i = 0;
  logic [2:0]  cur_mask_i = 0, volt_mask_i = 0;
  logic [4:0]  sw_ch_i = 0, rsp_ch_i = 0, cmd_ch_o, res_ch_o;
  logic        rsp_vld_i = 0;
  logic [11:0] rsp_data_i = 0, sw_data_o, res_data_o;
  logic        sw_ack_o, sw_done_o, cmd_vld_o, res_vld_o;
  logic        seq_busy_o, seq_done_o, trig_miss_o, tmo_err_o;

  bldc_adc_sched #(.MAX_OUT(MAXO), .TMO_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .trig_i(trig_i),
    .cur_mask_i(cur_mask_i), .volt_mask_i(volt_mask_i),
    .sw_req_i(sw_req_i), .sw_ch_i(sw_ch_i), .sw_ack_o(sw_ack_o),
    .sw_done_o(sw_done_o), .sw_data_o(sw_data_o),
    .cmd_vld_o(cmd_vld_o), .cmd_ch_o(cmd_ch_o), .cmd_ready_i(cmd_ready_i),
    .rsp_vld_i(rsp_vld_i), .rsp_ch_i(rsp_ch_i), .rsp_data_i(rsp_data_i),
    .res_vld_o(res_vld_o), .res_ch_o(res_ch_o), .res_data_o(res_data_o),
    .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o),
    .trig_miss_o(trig_miss_o), .tmo_err_o(tmo_err_o), .clr_err_i(clr_err_i));

  always #5 clk = ~clk;

  typedef struct {int due; logic [4:0] ch; logic [11:0] data;} adc_t;
  typedef struct {logic [4:0] ch; logic [11:0] data;} res_t;

  adc_t        adc_q[$];
  int          exp_cmd[$];
  res_t        exp_res[$];
  logic [11:0] exp_sw[$];
  int          xcyc[$];

  int checks = 0, errors = 0;
  int cyc = 0, n_done = 0, n_xfer = 0, n_sw = 0, done_cyc = 0, bench_out = 0;
  int adc_lat = 2;
  logic [11:0] adc_tag = 0;
  logic adc_mute = 0, prev_stall = 0, prev_en = 0;
  logic [4:0] prev_ch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int d0, input int bound, input string nm);
    int k = 0;
    while (n_done == d0 && k < bound) begin tick(1); k++; end
    if (n_done == d0) fail_evt(nm);
  endtask

  task automatic push_res(input int ch, input logic [11:0] data);
    res_t r;
    r.ch = 5'(ch);
    r.data = data;
    exp_res.push_back(r);
  endtask

  // ADC model: in-order responses adc_lat cycles after each transfer
  always begin
    adc_t e;
    @(posedge clk); #1;
    rsp_vld_i = 1'b0;
    if (!adc_mute && adc_q.size() > 0 && adc_q[0].due <= cyc) begin
      e = adc_q.pop_front();
      rsp_vld_i  = 1'b1;
      rsp_ch_i   = e.ch;
      rsp_data_i = e.data;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    adc_t a;
    res_t r;
    if (rst_n) begin
      if (cmd_vld_o) chk("out_limit", 32'(bench_out < MAXO), 1);
      if (prev_stall && prev_en) begin
        chk("cmd_hold_vld", 32'(cmd_vld_o), 1);
        chk("cmd_hold_ch", 32'(cmd_ch_o), 32'(prev_ch));
      end
      if (cmd_vld_o && cmd_ready_i) begin
        n_xfer++;
        xcyc.push_back(cyc);
        if (exp_cmd.size() == 0) fail_evt("unexpected_cmd");
        else chk("cmd_ch", 32'(cmd_ch_o), 32'(exp_cmd.pop_front()));
        a.due  = cyc + adc_lat;
        a.ch   = cmd_ch_o;
        a.data = (cmd_ch_o == 5'd7) ? 12'hABC : 12'h500 + adc_tag + {7'd0, cmd_ch_o};
        adc_q.push_back(a);
        bench_out++;
      end
      if (rsp_vld_i && bench_out > 0) bench_out--;
      if (res_vld_o) begin
        if (exp_res.size() == 0) fail_evt("unexpected_res");
        else begin
          r = exp_res.pop_front();
          chk("res_ch", 32'(res_ch_o), 32'(r.ch));
          chk("res_data", 32'(res_data_o), 32'(r.data));
        end
      end
      if (sw_done_o) begin
        n_sw++;
        if (exp_sw.size() == 0) fail_evt("unexpected_sw_done");
        else chk("sw_data", 32'(sw_data_o), 32'(exp_sw.pop_front()));
      end
      if (seq_done_o) begin n_done++; done_cyc = cyc; end
    end
    prev_stall = cmd_vld_o & ~cmd_ready_i;
    prev_en    = en_i;
    prev_ch    = cmd_ch_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0, x0, t0, k;
    tick(3);
    @(negedge clk);
    chk("rst_ctl", {cmd_vld_o, cmd_ch_o, sw_ack_o, sw_done_o, res_vld_o, res_ch_o,
                    seq_busy_o, seq_done_o, trig_miss_o, tmo_err_o}, 0);
    chk("rst_data", {sw_data_o, res_data_o}, 0);
    tick(1);
    rst_n = 1; en_i = 1; cmd_ready_i = 1;
    tick(2);

    // T1: full sequence, ADC answers 2 cycles after each command
    adc_tag = 12'h000; cur_mask_i = 3'b111; volt_mask_i = 3'b111;
    for (int c = 0; c < 6; c++) begin exp_cmd.push_back(c); push_res(c, 12'h500 + 12'(c)); end
    d0 = n_done; x0 = xcyc.size();
    trig_i = 1; tick(1); trig_i = 0;
    chk("t1_busy", 32'(seq_busy_o), 1);
    wait_done(d0, 60, "t1_no_done");
    tick(3);
    chk("t1_done_cnt", n_done - d0, 1);
    if (xcyc.size() >= x0 + 6) chk("t1_back2back", xcyc[x0+5] - xcyc[x0], 5);
    else fail_evt("t1_too_few_cmds");
    chk("t1_res_left", exp_res.size(), 0);
    chk("t1_busy_clr", 32'(seq_busy_o), 0);

    // T2: masks 101/010 with ready toggling every cycle
    adc_tag = 12'h020; cur_mask_i = 3'b101; volt_mask_i = 3'b010;
    exp_cmd.push_back(0); exp_cmd.push_back(2); exp_cmd.push_back(4);
    push_res(0, 12'h520); push_res(2, 12'h522); push_res(4, 12'h524);
    d0 = n_done; x0 = n_xfer;
    for (int i = 0; i < 60 && n_done == d0; i++) begin
      cmd_ready_i = i[0];
      trig_i = (i == 0);
      tick(1);
    end
    trig_i = 0; cmd_ready_i = 1;
    if (n_done == d0) fail_evt("t2_no_done");
    tick(3);
    chk("t2_xfers", n_xfer - x0, 3);
    chk("t2_res_left", exp_res.size(), 0);

    // T3: outstanding limit with ADC silent for 20 cycles
    adc_tag = 12'h030; cur_mask_i = 3'b111; volt_mask_i = 3'b111; adc_mute = 1;
    for (int c = 0; c < 6; c++) begin exp_cmd.push_back(c); push_res(c, 12'h530 + 12'(c)); end
    d0 = n_done; x0 = n_xfer;
    trig_i = 1; tick(1); trig_i = 0;
    tick(20);
    chk("t3_xfer_lim", n_xfer - x0, 4);
    chk("t3_vld_low", 32'(cmd_vld_o), 0);
    adc_mute = 0;
    wait_done(d0, 60, "t3_no_done");
    tick(3);
    chk("t3_xfer_all", n_xfer - x0, 6);
    chk("t3_res_left", exp_res.size(), 0);

    // T4: software request and trigger in the same IDLE cycle
    adc_tag = 12'h040; cur_mask_i = 3'b001; volt_mask_i = 3'b000; sw_ch_i = 5'd7;
    exp_cmd.push_back(0); exp_cmd.push_back(7);
    push_res(0, 12'h540); exp_sw.push_back(12'hABC);
    d0 = n_done; x0 = n_sw;
    trig_i = 1; sw_req_i = 1; tick(1); trig_i = 0;
    k = 0;
    while (!sw_ack_o && k < 60) begin tick(1); k++; end
    if (!sw_ack_o) fail_evt("t4_no_ack");
    sw_req_i = 0;
    k = 0;
    while (n_sw == x0 && k < 60) begin tick(1); k++; end
    if (n_sw == x0) fail_evt("t4_no_sw_done");
    tick(2);
    chk("t4_sw_data_hold", 32'(sw_data_o), 32'h0ABC);
    chk("t4_seq_done", n_done - d0, 1);
    chk("t4_res_left", exp_res.size(), 0);

    // T5: trigger during DRAIN is dropped and flagged
    adc_tag = 12'h050; adc_lat = 6; cur_mask_i = 3'b001;
    exp_cmd.push_back(0); push_res(0, 12'h550);
    d0 = n_done;
    trig_i = 1; tick(1); trig_i = 0;
    tick(4);
    chk("t5_busy", 32'(seq_busy_o), 1);
    trig_i = 1; tick(1); trig_i = 0;
    chk("t5_miss", 32'(trig_miss_o), 1);
    wait_done(d0, 40, "t5_no_done");
    tick(4);
    chk("t5_one_done", n_done - d0, 1);
    chk("t5_sticky", 32'(trig_miss_o), 1);
    clr_err_i = 1; tick(1); clr_err_i = 0;
    chk("t5_clr", 32'(trig_miss_o), 0);
    adc_lat = 2;

    // T6: response suppressed in DRAIN -> timeout
    adc_tag = 12'h060; adc_mute = 1; cur_mask_i = 3'b001;
    exp_cmd.push_back(0);
    d0 = n_done;
    trig_i = 1; tick(1); trig_i = 0;
    tick(1000);
    chk("t6_no_tmo_early", 32'(tmo_err_o), 0);
    chk("t6_busy_wait", 32'(seq_busy_o), 1);
    k = 0;
    while (!tmo_err_o && k < 100) begin tick(1); k++; end
    chk("t6_tmo", 32'(tmo_err_o), 1);
    tick(1);
    chk("t6_idle", 32'(seq_busy_o), 0);
    chk("t6_no_done", n_done - d0, 0);
    adc_q.delete(); bench_out = 0; adc_mute = 0;
    clr_err_i = 1; tick(1); clr_err_i = 0;
    chk("t6_clr", 32'(tmo_err_o), 0);

    // T7: both masks zero -> done 3 cycles after trigger, no commands
    cur_mask_i = 3'b000; volt_mask_i = 3'b000;
    d0 = n_done; x0 = n_xfer; t0 = cyc;
    trig_i = 1; tick(1); trig_i = 0;
    wait_done(d0, 10, "t7_no_done");
    chk("t7_done_lat", done_cyc - t0, 3);
    chk("t7_no_cmds", n_xfer - x0, 0);

    // T8: enable dropped while a command is stalled -> withdrawn, sequence ends
    cur_mask_i = 3'b111; cmd_ready_i = 0;
    d0 = n_done; x0 = n_xfer;
    trig_i = 1; tick(1); trig_i = 0;
    tick(2);
    chk("t8_stall_vld", 32'(cmd_vld_o), 1);
    en_i = 0; tick(2);
    chk("t8_withdrawn", 32'(cmd_vld_o), 0);
    wait_done(d0, 10, "t8_no_done");
    chk("t8_no_cmds", n_xfer - x0, 0);
    en_i = 1; cmd_ready_i = 1;

    tick(5);
    chk("end_cmd_q", exp_cmd.size(), 0);
    chk("end_res_q", exp_res.size(), 0);
    chk("end_sw_q", exp_sw.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bldc_adc_sched.md
Name: bldc_adc_sched

Overview:
- Schedules and arbitrates the shared ADC command/response interface of the BLDC controller.
- A PWM-synchronous trigger launches a sampling sequence: phase currents (ch0-2) first, then phase voltages (ch3-5), each channel individually masked.
- Software single-shot conversions on any channel are serviced in the gaps between sequences.
- Sits between the PWM timer / Wishbone register block and the ADC core; results are streamed to the register/capture logic.

Parameters:
- MAX_OUT, 4, maximum number of commands accepted by the ADC but not yet answered (1..7).
- TMO_W, 10, width of the response-timeout counter; timeout fires after 2^TMO_W-1 idle cycles.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en_i  in  1  scheduler enable
- trig_i  in  1  single-cycle PWM sample trigger
- cur_mask_i  in  3  enable bits for ch0..ch2; sampled at trigger
- volt_mask_i  in  3  enable bits for ch3..ch5; sampled at trigger
- sw_req_i  in  1  software conversion request; level, held until sw_ack_o
- sw_ch_i  in  5  software conversion channel
- sw_ack_o  out  1  pulse: software command accepted by the ADC
- sw_done_o  out  1  pulse: software result valid
- sw_data_o  out  12  software result; held until the next sw_done_o
- cmd_vld_o  out  1  ADC command valid
- cmd_ch_o  out  5  ADC command channel
- cmd_ready_i  in  1  ADC command ready
- rsp_vld_i  in  1  ADC response valid; responses arrive in command order
- rsp_ch_i  in  5  response channel
- rsp_data_i  in  12  response data
- res_vld_o  out  1  pulse: sequence result valid
- res_ch_o  out  5  sequence result channel
- res_data_o  out  12  sequence result data
- seq_busy_o  out  1  sequence in progress
- seq_done_o  out  1  pulse: all sequence responses received
- trig_miss_o  out  1  sticky: a trigger arrived while not in IDLE
- tmo_err_o  out  1  sticky: response timeout
- clr_err_i  in  1  clears trig_miss_o and tmo_err_o

Behaviour:
- Reset: all outputs 0, FSM in IDLE, out_cnt=0, timeout counter=0, latched masks=0.
- All outputs are registered.
- Command handshake:
  - A command transfers on cmd_vld_o & cmd_ready_i.
  - cmd_ch_o is stable while cmd_vld_o=1 and !cmd_ready_i.
  - cmd_vld_o is never asserted while out_cnt==MAX_OUT.
- out_cnt: +1 on transfer, -1 on rsp_vld_i; both in the same cycle leaves it unchanged. Saturates at 0; rsp_vld_i with out_cnt==0 is ignored.
- FSM states: IDLE, CUR, VOLT, DRAIN, SW, SW_WAIT.
- IDLE:
  - trig_i & en_i: latch both masks; go CUR; seq_busy_o=1 from the next cycle.
  - Otherwise, sw_req_i & en_i & out_cnt==0: go SW.
  - Trigger has priority over a software request in the same cycle.
- CUR: issue the set bits of the latched cur_mask in ascending channel order, one command per transfer. After the last transfer, or immediately if the mask is 0, go VOLT.
- VOLT: same rule over volt_mask, issuing channels 3..5. Then go DRAIN.
- DRAIN:
  - When out_cnt reaches 0, pulse seq_done_o for one cycle, clear seq_busy_o, go IDLE.
  - Both masks 0: no commands are issued, and seq_done_o pulses 3 cycles after trig_i (CUR, VOLT, DRAIN).
- Sequence results: each rsp_vld_i received while seq_busy_o=1 gives res_vld_o=1 one cycle later, with res_ch_o=rsp_ch_i and res_data_o=rsp_data_i. Latency is 1 cycle.
- SW: drive cmd_ch_o=sw_ch_i with cmd_vld_o=1. On transfer, pulse sw_ack_o and go SW_WAIT.
- SW_WAIT: the next rsp_vld_i is the software result. sw_done_o pulses 1 cycle later, sw_data_o=rsp_data_i, res_vld_o stays 0. Go IDLE.
- trig_i in any state other than IDLE: the trigger is dropped and trig_miss_o is set.
- Timeout:
  - The counter increments each cycle in DRAIN or SW_WAIT while out_cnt>0 and rsp_vld_i=0. It clears on any rsp_vld_i or state change.
  - At all-ones: set tmo_err_o, force out_cnt=0, go IDLE. No seq_done_o or sw_done_o pulse is issued.
- Sticky flags: clr_err_i clears both. A set event in the same cycle as clr_err_i wins.
- en_i deasserted mid-sequence:
  - CUR/VOLT go to DRAIN at once; no further commands are issued, and an in-flight command with cmd_vld_o=1 is withdrawn.
  - SW returns to IDLE without issuing.
  - DRAIN and SW_WAIT complete normally.
- Withdrawing cmd_vld_o without a transfer is permitted only on en_i deassertion.
- rst_n asserted mid-operation: immediate return to reset values; pending responses are discarded.

Test Plan:
- Full sequence: cur_mask=3'b111, volt_mask=3'b111, trigger, cmd_ready_i=1, ADC answers 2 cycles after each command -> commands on ch 0,1,2,3,4,5 on consecutive cycles; 6 res_vld_o pulses in that order; one seq_done_o.
- Mask and backpressure: cur_mask=3'b101, volt_mask=3'b010, cmd_ready_i toggled each cycle -> commands on ch 0,2,4 only; cmd_ch_o stable while stalled; 3 results.
- Outstanding limit: MAX_OUT=4, no responses for 20 cycles -> exactly 4 transfers, then cmd_vld_o=0; out_cnt resumes on responses.
- Software arbitration: sw_req_i (ch=7) and trig_i in the same IDLE cycle -> sequence runs first; then sw_ack_o; sw_done_o with sw_data_o=12'hABC; res_vld_o not asserted for it.
- Missed trigger: trig_i during DRAIN -> trig_miss_o=1 and no new sequence; clr_err_i -> flag 0.
- Timeout and zero mask: response suppressed in DRAIN -> tmo_err_o set after 1023 cycles, FSM returns to IDLE, no seq_done_o. Both masks 0 -> no commands issued, seq_done_o 3 cycles after trig_i.
